// File: rtl/alu_issue_queue.sv
// In-order ALU issue queue with CDB tag snooping and branch-mispredict flush.
// Optional macro ALU_ISSUE_BYPASS_EN adds a same-cycle CDB bypass onto the head operands.
module alu_issue_queue #(
  parameter int WIDTH  = 32,
  parameter int ALU_OP = 4,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ALU_OP-1:0]        in_op,
  input  logic [4:0]               in_shamt,
  input  logic [TAG_W-1:0]         in_dest_tag,
  input  logic [WIDTH-1:0]         in_src1_val,
  input  logic [WIDTH-1:0]         in_src2_val,
  input  logic [TAG_W-1:0]         in_src1_tag,
  input  logic [TAG_W-1:0]         in_src2_tag,
  input  logic                     in_src1_rdy,
  input  logic                     in_src2_rdy,
  input  logic                     cdb_valid,
  input  logic [TAG_W-1:0]         cdb_tag,
  input  logic [WIDTH-1:0]         cdb_data,
  input  logic                     flush,
  output logic                     alu_valid,
  input  logic                     alu_ready,
  output logic [ALU_OP-1:0]        alu_op,
  output logic [WIDTH-1:0]         alu_rd1,
  output logic [WIDTH-1:0]         alu_rd2,
  output logic [4:0]               alu_shifter_size,
  output logic [TAG_W-1:0]         alu_dest_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Entry storage
  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_src1_rdy;
  logic [DEPTH-1:0]  r_src2_rdy;
  logic [ALU_OP-1:0] r_op       [DEPTH];
  logic [4:0]        r_shamt    [DEPTH];
  logic [TAG_W-1:0]  r_dest_tag [DEPTH];
  logic [WIDTH-1:0]  r_src1_val [DEPTH];
  logic [WIDTH-1:0]  r_src2_val [DEPTH];
  logic [TAG_W-1:0]  r_src1_tag [DEPTH];
  logic [TAG_W-1:0]  r_src2_tag [DEPTH];

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_push;
  logic              w_pop;
  logic              w_hd1_rdy;
  logic              w_hd2_rdy;
  logic              w_in1_cap;
  logic              w_in2_cap;
  logic              w_in1_rdy;
  logic              w_in2_rdy;
  logic [WIDTH-1:0]  w_in1_val;
  logic [WIDTH-1:0]  w_in2_val;

  // Admission looks only at the registered count, so a pop never frees a slot the same cycle
  assign in_ready = (r_count < FULL_CNT) && !flush;
  assign w_push   = in_valid && in_ready;
  assign w_pop    = alu_valid && alu_ready;

  // A source arriving on the CDB in its own push cycle is captured directly
  assign w_in1_cap = cdb_valid && !in_src1_rdy && (in_src1_tag == cdb_tag);
  assign w_in2_cap = cdb_valid && !in_src2_rdy && (in_src2_tag == cdb_tag);
  assign w_in1_rdy = in_src1_rdy | w_in1_cap;
  assign w_in2_rdy = in_src2_rdy | w_in2_cap;
  assign w_in1_val = w_in1_cap ? cdb_data : in_src1_val;
  assign w_in2_val = w_in2_cap ? cdb_data : in_src2_val;

`ifdef ALU_ISSUE_BYPASS_EN
  logic w_hd1_cdb;
  logic w_hd2_cdb;

  assign w_hd1_cdb = cdb_valid && !r_src1_rdy[r_head] && (r_src1_tag[r_head] == cdb_tag);
  assign w_hd2_cdb = cdb_valid && !r_src2_rdy[r_head] && (r_src2_tag[r_head] == cdb_tag);
  assign w_hd1_rdy = r_src1_rdy[r_head] | w_hd1_cdb;
  assign w_hd2_rdy = r_src2_rdy[r_head] | w_hd2_cdb;
  assign alu_rd1   = w_hd1_cdb ? cdb_data : r_src1_val[r_head];
  assign alu_rd2   = w_hd2_cdb ? cdb_data : r_src2_val[r_head];
`else
  assign w_hd1_rdy = r_src1_rdy[r_head];
  assign w_hd2_rdy = r_src2_rdy[r_head];
  assign alu_rd1   = r_src1_val[r_head];
  assign alu_rd2   = r_src2_val[r_head];
`endif

  assign alu_valid        = r_valid[r_head] && w_hd1_rdy && w_hd2_rdy;
  assign alu_op           = r_op[r_head];
  assign alu_shifter_size = r_shamt[r_head];
  assign alu_dest_tag     = r_dest_tag[r_head];
  assign count            = r_count;

  // Control: valid bits, pointers and occupancy; flush outranks push and pop
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload: CDB wakeup of waiting operands, then the tail write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_src1_rdy <= '0;
      r_src2_rdy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_op[i]       <= '0;
        r_shamt[i]    <= '0;
        r_dest_tag[i] <= '0;
        r_src1_val[i] <= '0;
        r_src2_val[i] <= '0;
        r_src1_tag[i] <= '0;
        r_src2_tag[i] <= '0;
      end
    end else if (!flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cdb_valid && r_valid[i] && !r_src1_rdy[i] && (r_src1_tag[i] == cdb_tag)) begin
          r_src1_val[i] <= cdb_data;
          r_src1_rdy[i] <= 1'b1;
        end
        if (cdb_valid && r_valid[i] && !r_src2_rdy[i] && (r_src2_tag[i] == cdb_tag)) begin
          r_src2_val[i] <= cdb_data;
          r_src2_rdy[i] <= 1'b1;
        end
      end
      if (w_push) begin
        r_op[r_tail]       <= in_op;
        r_shamt[r_tail]    <= in_shamt;
        r_dest_tag[r_tail] <= in_dest_tag;
        r_src1_val[r_tail] <= w_in1_val;
        r_src2_val[r_tail] <= w_in2_val;
        r_src1_tag[r_tail] <= in_src1_tag;
        r_src2_tag[r_tail] <= in_src2_tag;
        r_src1_rdy[r_tail] <= w_in1_rdy;
        r_src2_rdy[r_tail] <= w_in2_rdy;
      end
    end
  end

endmodule
